// File: rtl/chocorol_pkg.sv
// Shared definitions for the ChocoRol sequencer slice.
//   IW_DEF / RW_DEF : default instruction and result widths of the datapath
//   STATS_W         : width of the optional issued-result counter
//   state_e         : sequencer FSM states
package chocorol_pkg;

  localparam int unsigned IW_DEF  = 20;
  localparam int unsigned RW_DEF  = 20;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/chocorol_fifo.sv
// Synchronous FIFO, first-word-fall-through read port.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request / data (ignored while full)
//   pop, rdata    : read request (ignored while empty) / head of queue
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..DEPTH
module chocorol_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/chocorol_secuenciador.sv
// Feeds queued instruction words to the combinational ChocoRol datapath one
// at a time, holds each for SETTLE cycles, captures R and offers it to the
// consumer with a valid/ready handshake.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   : instruction input handshake
//   dp_instr / dp_r              : datapath Instruccion drive / result R
//   out_valid/out_ready/out_result : result output handshake
//   busy                         : FSM active or FIFO non-empty
//   fifo_count                   : FIFO occupancy
//   issued_count                 : handshake counter, present only when
//                                  CHOCOROL_STATS_EN is defined
module chocorol_secuenciador
  import chocorol_pkg::*;
#(
  parameter int unsigned IW     = IW_DEF,
  parameter int unsigned RW     = RW_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          in_instr,
  output logic [IW-1:0]          dp_instr,
  input  logic [RW-1:0]          dp_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_result,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef CHOCOROL_STATS_EN
  ,
  output logic [STATS_W-1:0]     issued_count
`endif
);

  localparam int unsigned CW = $clog2(SETTLE) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] dp_q, dp_d;
  logic [RW-1:0] res_q, res_d;
  logic          valid_q, valid_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [IW-1:0] fifo_head;

  // Full is taken from the registered count, so a pop in the same cycle
  // never opens room for a push.
  assign in_ready  = !rst && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  chocorol_fifo #(
    .DEPTH (DEPTH),
    .W     (IW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_instr),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    res_d   = res_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          dp_d    = fifo_head;
          cnt_d   = CW'(SETTLE - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        // dp_r is only trusted once the full settle window has elapsed.
        if (cnt_q == '0) begin
          res_d   = dp_r;
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dp_q    <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign dp_instr   = dp_q;
  assign out_result = res_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;

`ifdef CHOCOROL_STATS_EN
  logic [STATS_W-1:0] issued_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
    end else if (valid_q && out_ready) begin
      issued_q <= issued_q + STATS_W'(1);
    end
  end

  assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_chocorol_secuenciador.sv
module tb_chocorol_secuenciador;

  logic        clk = 1'b0;
  logic        rst;

  // Instance A: SETTLE=1, datapath stub R = ~Instruccion
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [19:0] in_instr, dp_instr, dp_r, out_result;
  logic [2:0]  fifo_count;

  // Instance B: SETTLE=3, stub R reaches ~Instruccion two edges after a change
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [19:0] b_in_instr, b_dp_instr, b_dp_r, b_out_result;
  logic [2:0]  b_fifo_count;
  logic [19:0] b_dly1, b_dly2;

`ifdef CHOCOROL_STATS_EN
  logic [15:0] issued_count, b_issued_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] qa[$];
  logic [19:0] qb[$];
  logic acc_a, acc_b;

  always #5 clk = ~clk;

  assign dp_r = ~dp_instr;

  always @(posedge clk) begin
    b_dly1 <= ~b_dp_instr;
    b_dly2 <= b_dly1;
  end
  assign b_dp_r = b_dly2;

  chocorol_secuenciador #(.IW(20), .RW(20), .DEPTH(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .dp_instr(dp_instr), .dp_r(dp_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .fifo_count(fifo_count)
`ifdef CHOCOROL_STATS_EN
    , .issued_count(issued_count)
`endif
  );

  chocorol_secuenciador #(.IW(20), .RW(20), .DEPTH(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .dp_instr(b_dp_instr), .dp_r(b_dp_r),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
    .busy(b_busy), .fifo_count(b_fifo_count)
`ifdef CHOCOROL_STATS_EN
    , .issued_count(b_issued_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the negedge (before the active edge),
  // run the scoreboards, then step to just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    acc_a = in_valid && in_ready;
    acc_b = b_in_valid && b_in_ready;
    if (acc_a) qa.push_back(~in_instr);
    if (acc_b) qb.push_back(~b_in_instr);
    if (!rst && out_valid && out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_result", {12'h0, out_result}, 32'hFFFFFFFF);
      else                chk("a_result", {12'h0, out_result}, {12'h0, qa.pop_front()});
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_result", {12'h0, b_out_result}, 32'hFFFFFFFF);
      else                chk("b_result", {12'h0, b_out_result}, {12'h0, qb.pop_front()});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (qa.size() != 0 && n < 80) begin cycle(); n++; end
    chk(tag, qa.size(), 0);
  endtask

  task automatic drain_b(input string tag);
    int n = 0;
    while (qb.size() != 0 && n < 80) begin cycle(); n++; end
    chk(tag, qb.size(), 0);
  endtask

  initial begin
    logic [19:0] burst [5];
    int lat;
    int n;
    burst[0] = 20'h4ECA0; burst[1] = 20'h01C40; burst[2] = 20'h01C43;
    burst[3] = 20'h48803; burst[4] = 20'h4ECA0;

    rst = 1'b1;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b0;
    repeat (3) cycle();

    // Reset values, with rst still asserted
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_dp_instr", dp_instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_b_in_ready", b_in_ready, 0);

    // Single instruction, minimum latency
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 20'h48803;
    cycle();
    chk("single_accept", acc_a, 1);
    in_valid = 1'b0;
    chk("single_count", fifo_count, 1);
    cycle();
    chk("single_dp_instr", dp_instr, 20'h48803);
    chk("single_valid_early", out_valid, 0);
    chk("single_busy", busy, 1);
    cycle();
    chk("single_out_valid", out_valid, 1);
    chk("single_out_result", out_result, 20'hB77FC);

    // Hold the result back, then fill the FIFO behind it
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = burst[i];
      cycle();
      chk("burst_accept", acc_a, 1);
    end
    in_instr = burst[4];
    chk("burst_full_count", fifo_count, 4);
    chk("burst_full_in_ready", in_ready, 0);

    // Backpressure for 10 cycles: fifth word stalled, output frozen
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_stalled", acc_a, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_result", out_result, 20'hB77FC);
      chk("bp_dp_instr", dp_instr, 20'h48803);
    end

    out_ready = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!acc_a && n < 20);
    chk("burst_fifth_accepted", acc_a, 1);
    in_valid = 1'b0;
    drain_a("burst_drain");
    repeat (2) cycle();
    chk("burst_idle_busy", busy, 0);
    chk("burst_idle_count", fifo_count, 0);

    // SETTLE=3: capture only after the stub has settled
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_instr = 20'h01C43;
    cycle();
    chk("settle_accept", acc_b, 1);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin cycle(); lat++; end
    chk("settle_latency", lat, 4);
    chk("settle_result1", b_out_result, 20'hFE3BC);
    drain_b("settle_drain1");
    b_in_valid = 1'b1; b_in_instr = 20'h4ECA0;
    cycle();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin cycle(); lat++; end
    chk("settle_result2", b_out_result, 20'hB135F);
    drain_b("settle_drain2");

    // Reset while in HOLD with two words queued
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_instr = burst[i];
      cycle();
    end
    b_in_valid = 1'b0;
    chk("midrst_pre_count", b_fifo_count, 2);
    chk("midrst_pre_valid", b_out_valid, 0);
    rst = 1'b1;
    cycle();
    qa.delete();
    qb.delete();
    chk("midrst_count", b_fifo_count, 0);
    chk("midrst_out_valid", b_out_valid, 0);
    chk("midrst_dp_instr", b_dp_instr, 0);
    chk("midrst_busy", b_busy, 0);
    rst = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("midrst_no_stale", b_out_valid, 0);
    end
    chk("midrst_out_result", b_out_result, 0);

`ifdef CHOCOROL_STATS_EN
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = burst[i];
      cycle();
    end
    in_valid = 1'b0;
    drain_a("stats_drain");
    chk("stats_three", issued_count, 3);
    force dut_a.issued_q = 16'hFFFF;
    #1;
    release dut_a.issued_q;
    in_valid = 1'b1; in_instr = 20'h01C40;
    cycle();
    in_valid = 1'b0;
    drain_a("stats_drain_wrap");
    chk("stats_wrap", issued_count, 0);
`endif

    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
